sram_like_arbiter: RTL and testbench

- Shares one sram-like memory port between the instruction-fetch requester (inst_*) and the load/store requester (data_*).
- Arbitrates address-phase requests and locks the grant until the address handshake completes.
- Records the source of every accepted request in an in-order tag FIFO, and routes each returned data_ok/rdata back to that requester.
- Sits between the pipeline (IF/EXE/MEM) and the later memory-bus bridge.

---
 rtl/sram_like_arbiter_pkg.sv | 25 ++
 rtl/sram_like_arbiter_tag.sv | 56 +++++
 rtl/sram_like_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and constants for the sram-like port arbiter.
// Optional ARB_ROUND_ROBIN_EN is consumed by sram_like_arbiter.
package sram_like_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/sram_like_arbiter_tag.sv
// In-order source tag FIFO: one bit per accepted,
// not yet returned memory request.
module arb_tag_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_en;
  logic             pop_en;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_en, pop_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between fetch and load/store.
// `define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_unexp
);

  lock_state_t state, state_nxt;
  logic        lock_src, lock_nxt;
  logic        lock_hold;
  logic        win_src;
  logic        win_req;
  logic        hs;
  logic        stall;
  logic        pop;
  logic        full, empty, head;
  mem_cmd_t    inst_cmd, data_cmd, win_cmd;
`ifdef ARB_ROUND_ROBIN_EN
  logic        rr_last;
`endif

  assign inst_cmd = {inst_wr, inst_size, inst_addr,
                     inst_wstrb, inst_wdata};
  assign data_cmd = {data_wr, data_size, data_addr,
                     data_wstrb, data_wdata};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      lock_src <= SRC_INST;
    end else begin
      state    <= state_nxt;
      lock_src <= lock_nxt;
    end
  end

  // Next state: a dropped locked request frees the port at once
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_src;
    unique case (state)
      ST_IDLE: begin
        if (stall) begin
          state_nxt = ST_LOCKED;
          lock_nxt  = win_src;
        end
      end
      ST_LOCKED: begin
        if (hs) begin
          state_nxt = ST_IDLE;
        end else if (!lock_hold) begin
          if (stall) begin
            lock_nxt = win_src;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: grant selection and command mux
  always_comb begin
    lock_hold = (state == ST_LOCKED) &&
                ((lock_src == SRC_DATA) ? data_req : inst_req);
    if (lock_hold) begin
      win_src = lock_src;
`ifdef ARB_ROUND_ROBIN_EN
    end else if (inst_req && data_req) begin
      win_src = ~rr_last;
`endif
    end else if (data_req) begin
      win_src = SRC_DATA;
    end else begin
      win_src = SRC_INST;
    end
    win_req = (win_src == SRC_DATA) ? data_req : inst_req;

    win_cmd = '0;
    unique case (1'b1)
      win_req && (win_src == SRC_DATA): win_cmd = data_cmd;
      win_req && (win_src == SRC_INST): win_cmd = inst_cmd;
      default:                          win_cmd = '0;
    endcase

    mem_req = win_req & ~full & resetn;
    hs      = mem_req & mem_addr_ok;
    stall   = mem_req & ~mem_addr_ok;
    pop     = mem_data_ok & ~empty & resetn;

    inst_addr_ok = hs & (win_src == SRC_INST);
    data_addr_ok = hs & (win_src == SRC_DATA);
    inst_data_ok = pop & (head == SRC_INST);
    data_data_ok = pop & (head == SRC_DATA);
  end

  assign {mem_wr, mem_size, mem_addr,
          mem_wstrb, mem_wdata} = win_cmd;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_unexp <= 1'b0;
    end else if (mem_data_ok && empty) begin
      err_unexp <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last <= SRC_INST;
    end else if (hs) begin
      rr_last <= win_src;
    end
  end
`endif

  arb_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (hs),
    .pop    (pop),
    .din    (win_src),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with a return-order
// scoreboard; honours ARB_ROUND_ROBIN_EN when defined.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_unexp;

  int n_pass = 0;
  int n_total = 0;
  logic sb[$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTST(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .err_unexp(err_unexp)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic settle();
    #4;
  endtask

  // Record accepted requests, then move to just after the next edge
  task automatic adv();
    if (inst_addr_ok) sb.push_back(SRC_INST);
    if (data_addr_ok) sb.push_back(SRC_DATA);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    logic src;
    chk({tag, "_sb_has"}, 32'(sb.size() != 0), 32'd1);
    src = (sb.size() != 0) ? sb.pop_front() : SRC_INST;
    chk({tag, "_inst_dok"}, 32'(inst_data_ok),
        32'(src == SRC_INST));
    chk({tag, "_data_dok"}, 32'(data_data_ok),
        32'(src == SRC_DATA));
    chk({tag, "_inst_rd"}, inst_rdata, mem_rdata);
    chk({tag, "_data_rd"}, data_rdata, mem_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = SIZE_W;
    inst_addr = 32'h1c00_0000; inst_wstrb = 4'h0;
    inst_wdata = 32'h0;
    data_req = 0; data_wr = 1; data_size = SIZE_W;
    data_addr = 32'h8000_0100; data_wstrb = 4'hf;
    data_wdata = 32'hdead_beef;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    #2;
    inst_req = 1; mem_addr_ok = 1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_inst_aok", 32'(inst_addr_ok), 32'd0);
    chk("rst_err", 32'(err_unexp), 32'd0);
    inst_req = 0; mem_addr_ok = 0;
    @(posedge clk); @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // 1: single fetch, return three cycles later
    inst_req = 1; mem_addr_ok = 1;
    settle();
    chk("t1_inst_aok", 32'(inst_addr_ok), 32'd1);
    chk("t1_data_aok", 32'(data_addr_ok), 32'd0);
    chk("t1_addr", mem_addr, 32'h1c00_0000);
    chk("t1_wr", 32'(mem_wr), 32'd0);
    adv();
    inst_req = 0; mem_addr_ok = 0;
    settle(); chk("t1_idle_req", 32'(mem_req), 32'd0);
    adv(); adv();
    mem_data_ok = 1; mem_rdata = 32'h0280_0000;
    settle();
    chk_ret("t1_ret");
    chk("t1_rdata", inst_rdata, 32'h0280_0000);
    adv();
    mem_data_ok = 0;

    // 2: simultaneous requests, data first
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    inst_addr = 32'h1c00_0004;
    settle();
    chk("t2_data_aok", 32'(data_addr_ok), 32'd1);
    chk("t2_inst_aok0", 32'(inst_addr_ok), 32'd0);
    chk("t2_addr_d", mem_addr, 32'h8000_0100);
    chk("t2_wdata", mem_wdata, 32'hdead_beef);
    chk("t2_wstrb", 32'(mem_wstrb), 32'hf);
    adv();
    data_req = 0;
    settle();
    chk("t2_inst_aok", 32'(inst_addr_ok), 32'd1);
    chk("t2_addr_i", mem_addr, 32'h1c00_0004);
    adv();
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'h1111_0000;
    settle(); chk_ret("t2_ret_d");
    chk("t2_dok_d", 32'(data_data_ok), 32'd1);
    adv();
    mem_rdata = 32'h2222_0000;
    settle(); chk_ret("t2_ret_i");
    chk("t2_iok_i", 32'(inst_data_ok), 32'd1);
    adv();
    mem_data_ok = 0;

    // 3: locked grant holds against a later data request
    inst_req = 1; inst_addr = 32'h1c00_0008;
    settle();
    chk("t3_c0_addr", mem_addr, 32'h1c00_0008);
    adv();
    data_req = 1; data_addr = 32'h8000_0200;
    settle();
    chk("t3_c1_addr", mem_addr, 32'h1c00_0008);
    chk("t3_c1_req", 32'(mem_req), 32'd1);
    adv();
    settle();
    chk("t3_c2_addr", mem_addr, 32'h1c00_0008);
    adv();
    mem_addr_ok = 1;
    settle();
    chk("t3_inst_aok", 32'(inst_addr_ok), 32'd1);
    chk("t3_data_aok0", 32'(data_addr_ok), 32'd0);
    adv();
    inst_req = 0;
    settle();
    chk("t3_data_aok", 32'(data_addr_ok), 32'd1);
    chk("t3_addr_d", mem_addr, 32'h8000_0200);
    adv();
    data_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'h3333_0001;
    settle(); chk_ret("t3_ret_i"); adv();
    mem_rdata = 32'h3333_0002;
    settle(); chk_ret("t3_ret_d"); adv();
    mem_data_ok = 0;

    // 4: outstanding limit
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h1c00_0100 + 32'(i * 4);
      settle();
      chk("t4_fill_aok", 32'(inst_addr_ok), 32'd1);
      adv();
    end
    mem_data_ok = 1; mem_rdata = 32'h4444_0000;
    settle();
    chk("t4_full_req", 32'(mem_req), 32'd0);
    chk("t4_full_aok", 32'(inst_addr_ok), 32'd0);
    chk_ret("t4_pop1");
    adv();
    mem_rdata = 32'h4444_0001;
    settle();
    chk("t4_refill_req", 32'(mem_req), 32'd1);
    chk("t4_refill_aok", 32'(inst_addr_ok), 32'd1);
    chk_ret("t4_pushpop");
    adv();
    mem_data_ok = 0;
    settle();
    chk("t4_three_req", 32'(mem_req), 32'd1);
    adv();
    settle();
    chk("t4_full2_req", 32'(mem_req), 32'd0);
    adv();
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'h5555_0000 + 32'(i);
      settle(); chk_ret("t4_drain"); adv();
    end
    mem_data_ok = 0;

    // 5: unexpected return, sticky error, async clear
    mem_data_ok = 1; mem_rdata = 32'h6666_0000;
    settle();
    chk("t5_iok", 32'(inst_data_ok), 32'd0);
    chk("t5_dok", 32'(data_data_ok), 32'd0);
    adv();
    mem_data_ok = 0;
    settle(); chk("t5_err", 32'(err_unexp), 32'd1);
    adv();
    settle(); chk("t5_err_held", 32'(err_unexp), 32'd1);
    resetn = 0;
    #1;
    chk("t5_err_clr", 32'(err_unexp), 32'd0);
    adv();
    resetn = 1;
    adv();

    // 6: both requests held every cycle
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
`ifdef ARB_ROUND_ROBIN_EN
      chk("t6_rr_data", 32'(data_addr_ok), 32'((i % 2) == 0));
      chk("t6_rr_inst", 32'(inst_addr_ok), 32'((i % 2) == 1));
`else
      chk("t6_fp_data", 32'(data_addr_ok), 32'd1);
      chk("t6_fp_inst", 32'(inst_addr_ok), 32'd0);
`endif
      adv();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'h7777_0000 + 32'(i);
      settle(); chk_ret("t6_drain"); adv();
    end
    mem_data_ok = 0;
    settle();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("end_err", 32'(err_unexp), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
